pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Drives the load-enable and flush/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions in the same cycle they occur: multi-cycle data-memory accesses, load-use hazards and taken branches. It also supervises data-memory latency with a timeout, and keeps a stall-cycle counter for performance debug.

## Interface
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before declaring a memory error (≥2).
- CNT_W, 32: width of the stall counter.

- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_ex_mem_read  in  1  the instruction in EX is a load.
- id_ex_rt  in  5  destination of that load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- dm_req  in  1  MEM stage is issuing a load/store this cycle.
- dm_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  synchronous clear of the register (control fields zeroed) on the next edge.
- mem_wb_bubble  out  1  MEM/WB captures reg_write=0, mem_to_reg=0 instead of EX/MEM values.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- Control outputs are combinational from the registered state and the current inputs. The state, wait counter, mem_err and stall_cnt are registered.
- While rst=1: state=RUN, wait counter=0, mem_err=0, stall_cnt=0, all enables 0, if_id_flush=id_ex_flush=mem_wb_bubble=1.
- States: RUN, MEM_WAIT, ERR.
- RUN decisions, in priority order:
  - Memory stall (dm_req && !dm_ready):
    - pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_en=1 with mem_wb_bubble=1.
    - Branch and load-use are ignored this cycle.
    - Next state is MEM_WAIT, wait counter=1.
  - Branch (ex_branch_taken): all enables 1, if_id_flush=1, id_ex_flush=1. Load-use is ignored because the ID instruction is being squashed.
  - Load-use (id_ex_mem_read && id_ex_rt≠0 && (id_ex_rt==id_rs || id_ex_rt==id_rt)):
    - pc_en=0 and if_id_en=0.
    - id_ex_en=1 with id_ex_flush=1 (bubble into EX).
    - ex_mem_en=mem_wb_en=1.
  - Otherwise: all enables 1, no flush, no bubble.
- MEM_WAIT:
  - dm_ready=1: apply the RUN decision rules with the memory stall suppressed (the access completes), next state RUN, counter cleared.
  - dm_ready=0: same outputs as the memory stall, counter+1. When counter==MEM_TIMEOUT-1, next state is ERR.
- ERR: all enables 0, mem_wb_bubble=1, mem_err=1. The block leaves ERR only on rst.
- stall_cnt increments on every non-reset edge where pc_en=0, including ERR. It holds at 2^CNT_W−1.
- Register $0 never causes a load-use stall. id_rs and id_rt are compared even when the instruction does not read them (conservative).

## Timing
- Zero-cycle decision latency: an input change is reflected in the outputs in the same cycle.
- A load-use hazard costs exactly 1 stall cycle. A taken branch costs 2 squashed slots, with no stall.
- A memory access with dm_ready asserted k cycles after dm_req costs k stall cycles. A single-cycle memory (dm_ready with dm_req) costs 0.
- mem_err rises on the edge after the (MEM_TIMEOUT−1)th wait cycle without dm_ready. A dm_ready arriving in that final cycle wins: the block returns to RUN with no error.
- rst asserted mid-MEM_WAIT or in ERR returns the block to RUN asynchronously; the pending access is abandoned.

## Structure
- pipe_ctrl_pkg: state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2), REG_ZERO=5'd0, and a struct bundling the five enables plus flush/bubble bits.
- One sub-module, load_use_detect: combinational comparator producing the hazard bit, reused by the forwarding unit.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rt=5, id_rs=5 in RUN → pc_en=if_id_en=0, id_ex_flush=1, stall_cnt 0→1. The same case with id_ex_rt=0 → no stall.
- Branch and load-use together: ex_branch_taken=1 with a load-use hit → all enables 1, if_id_flush=id_ex_flush=1, stall_cnt unchanged.
- Memory latency: dm_req=1, dm_ready asserted 3 cycles later → 3 cycles of pc_en=0 with mem_wb_bubble=1, then RUN, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dm_ready held 0 → ERR after 4 wait cycles, mem_err=1, all enables 0. Next, assert rst → mem_err=0, state RUN.
- Boundary: with MEM_TIMEOUT=4, dm_ready arrives in the 3rd wait cycle → no error, RUN resumes.
- Saturation: CNT_W=4, 20 forced stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bundle of every control line driven into the pipeline registers.
  typedef struct packed {
    logic pcEn;
    logic ifIdEn;
    logic idExEn;
    logic exMemEn;
    logic memWbEn;
    logic ifIdFlush;
    logic idExFlush;
    logic memWbBubble;
  } ctrl_t;

  // Canonical control patterns, MSB first in the field order above.
  localparam ctrl_t CTRL_RESET    = ctrl_t'(8'b00000_111);
  localparam ctrl_t CTRL_ERR      = ctrl_t'(8'b00000_001);
  localparam ctrl_t CTRL_MEMSTALL = ctrl_t'(8'b00001_001);
  localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b11111_110);
  localparam ctrl_t CTRL_LOADUSE  = ctrl_t'(8'b00111_010);
  localparam ctrl_t CTRL_RUN      = ctrl_t'(8'b11111_000);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator; also shared with the forwarding unit.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_idRs,
  input  logic [4:0] i_idRt,
  input  logic       i_exMemRead,
  input  logic [4:0] i_exRt,
  output logic       o_hazard
);

  // Register $0 is hard-wired, so a load targeting it can never cause a hazard.
  // Both sources are compared even if the ID instruction does not read them.
  assign o_hazard = i_exMemRead && (i_exRt != REG_ZERO) &&
                    ((i_exRt == i_idRs) || (i_exRt == i_idRt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: memory waits,
// load-use stalls, taken-branch squashes, memory timeout and stall counting.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            r_state;
  state_t            w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_nextWaitCnt;
  logic              r_memErr;
  logic              w_nextMemErr;
  logic [CNT_W-1:0]  r_stallCnt;
  logic              w_loadUse;
  ctrl_t             w_pipeCtrl;
  ctrl_t             w_ctrl;

  load_use_detect u_loadUseDetect (
    .i_idRs      (id_rs),
    .i_idRt      (id_rt),
    .i_exMemRead (id_ex_mem_read),
    .i_exRt      (id_ex_rt),
    .o_hazard    (w_loadUse)
  );

  // Pipeline decision when memory is not holding things up: a taken branch
  // squashes the ID instruction, so it outranks a load-use hit.
  always_comb begin
    w_pipeCtrl = CTRL_RUN;
    if (ex_branch_taken) begin
      w_pipeCtrl = CTRL_BRANCH;
    end else if (w_loadUse) begin
      w_pipeCtrl = CTRL_LOADUSE;
    end
  end

  // Next-state and control outputs; a completing access in MEM_WAIT falls
  // through to the normal pipeline decision in the same cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_nextMemErr  = r_memErr;
    w_ctrl        = CTRL_RUN;
    if (rst) begin
      w_ctrl = CTRL_RESET;
    end else begin
      case (r_state)
        RUN: begin
          if (dm_req && !dm_ready) begin
            w_ctrl        = CTRL_MEMSTALL;
            w_nextState   = MEM_WAIT;
            w_nextWaitCnt = WAIT_W'(1);
          end else begin
            w_ctrl = w_pipeCtrl;
          end
        end
        MEM_WAIT: begin
          if (dm_ready) begin
            w_ctrl        = w_pipeCtrl;
            w_nextState   = RUN;
            w_nextWaitCnt = '0;
          end else begin
            w_ctrl = CTRL_MEMSTALL;
            if (r_waitCnt == WAIT_LAST) begin
              w_nextState   = ERR;
              w_nextMemErr  = 1'b1;
              w_nextWaitCnt = '0;
            end else begin
              w_nextWaitCnt = r_waitCnt + 1'b1;
            end
          end
        end
        ERR: begin
          w_ctrl = CTRL_ERR;
        end
        default: begin
          w_nextState   = RUN;
          w_nextWaitCnt = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Wait counter, sticky error flag and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt  <= '0;
      r_memErr   <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_waitCnt <= w_nextWaitCnt;
      r_memErr  <= w_nextMemErr;
      if (!w_ctrl.pcEn && (r_stallCnt != CNT_MAX)) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
    end
  end

  assign pc_en         = w_ctrl.pcEn;
  assign if_id_en      = w_ctrl.ifIdEn;
  assign id_ex_en      = w_ctrl.idExEn;
  assign ex_mem_en     = w_ctrl.exMemEn;
  assign mem_wb_en     = w_ctrl.memWbEn;
  assign if_id_flush   = w_ctrl.ifIdFlush;
  assign id_ex_flush   = w_ctrl.idExFlush;
  assign mem_wb_bubble = w_ctrl.memWbBubble;
  assign mem_err       = r_memErr;
  assign stall_cnt     = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = 15;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic             ex_branch_taken;
  logic             dm_req;
  logic             dm_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive stalled cycles of the outstanding access
  // (0 = none), sticky error, and stall cycles seen since reset.
  int mWait   = 0;
  bit mErr    = 1'b0;
  int mStalls = 0;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rt        (id_ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .dm_req          (dm_req),
    .dm_ready        (dm_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the same-cycle outputs against the
  // model, then advances the model and the clock.
  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic mr, input logic [4:0] ert, input logic br,
                               input logic rq, input logic rd);
    logic [7:0] exp;
    bit         memStall;
    bit         loadUse;
    rst = r; id_rs = rs; id_rt = rt; id_ex_mem_read = mr; id_ex_rt = ert;
    ex_branch_taken = br; dm_req = rq; dm_ready = rd;
    #2;
    memStall = 1'b0;
    loadUse  = mr && (ert != 5'd0) && ((ert == rs) || (ert == rt));
    if (r) begin
      mWait = 0; mErr = 1'b0; mStalls = 0;
      exp = 8'b00000_111;
    end else if (mErr) begin
      exp = 8'b00000_001;
    end else begin
      memStall = (mWait > 0) ? !rd : (rq && !rd);
      if (memStall)     exp = 8'b00001_001;
      else if (br)      exp = 8'b11111_110;
      else if (loadUse) exp = 8'b00111_010;
      else              exp = 8'b11111_000;
    end
    checkOutput("ctrl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush, mem_wb_bubble}, {24'd0, exp});
    checkOutput("mem_err", {31'd0, mem_err}, {31'd0, mErr});
    checkOutput("stall_cnt", {28'd0, stall_cnt}, mStalls);
    if (!r) begin
      if (!exp[7] && mStalls < CNT_MAX) mStalls++;
      if (!mErr) begin
        if (memStall) begin
          mWait++;
          if (mWait == MEM_TIMEOUT) begin
            mErr  = 1'b1;
            mWait = 0;
          end
        end else begin
          mWait = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Load-use hit, then the same with a $0 destination
    applyStimulus(1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);

    // Branch together with a load-use hit
    applyStimulus(1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    idle();

    // Memory ready three cycles after request, then a single-cycle access
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mem_lat_cnt", {28'd0, stall_cnt}, 32'd3);
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Ready arriving in the last allowed wait cycle wins over the timeout
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    // (the loop above already times out; restart to exercise the boundary cleanly)
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("boundary_err", {31'd0, mem_err}, 32'd0);
    idle();

    // Timeout into ERR, linger, then reset out of it
    for (int i = 0; i < MEM_TIMEOUT; i++) applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("timeout_err", {31'd0, mem_err}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Saturation of the stall counter
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 5'd6, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_cnt", {28'd0, stall_cnt}, 32'd15);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) < 2),
                    ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
